// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_controller
//  Description : Instruction register, decoder and control FSM for a simple
//                16-bit datapath. Captures an instruction word, then steps
//                the datapath through read / execute / write-back, one state
//                per clock, driving every datapath control input.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     rising-edge clock
//    reset                   asynchronous, active-high reset
//    s                       start execution of IR contents (sampled in WAIT)
//    load                    capture `in` into IR (honoured only in WAIT)
//    in[15:0]                instruction word
//    w                       1 while in WAIT (ready for next instruction)
//    halted                  1 in HALT state
//    vsel[1:0]               writeback select: 00 mdata, 01 sximm8, 10 PC, 11 C
//    asel / bsel             ALU A-zero select / sximm5 B-operand select
//    loada/loadb/loadc/loads datapath register enables
//    write                   register-file write enable
//    readnum/writenum[2:0]   register-file addresses
//    ALUop[1:0], shift[1:0]  ALU operation and shifter control
//    sximm5/sximm8[15:0]     sign-extended IR[4:0] / IR[7:0]
// ----------------------------------------------------------------------------
//  Build option
//    HALT_INSN_EN  when defined, opcode 111 enters a HALT state that only
//                  reset leaves; otherwise opcode 111 is treated as undefined.
// ============================================================================
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        halted,
    output logic [1:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    localparam logic [2:0] c_S_WAIT      = 3'd0;
    localparam logic [2:0] c_S_DECODE    = 3'd1;
    localparam logic [2:0] c_S_WRITE_IMM = 3'd2;
    localparam logic [2:0] c_S_GET_A     = 3'd3;
    localparam logic [2:0] c_S_GET_B     = 3'd4;
    localparam logic [2:0] c_S_ALU       = 3'd5;
    localparam logic [2:0] c_S_WRITE_REG = 3'd6;
`ifdef HALT_INSN_EN
    localparam logic [2:0] c_S_HALT      = 3'd7;
    localparam logic [2:0] c_OPC_HALT    = 3'b111;
`endif

    localparam logic [2:0] c_OPC_MOV     = 3'b110;
    localparam logic [2:0] c_OPC_ALU     = 3'b101;

    logic [15:0] r_ir;
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;

    // Registered copies of the Moore outputs
    logic        r_w;
    logic [1:0]  r_vsel;
    logic        r_asel;
    logic        r_loada, r_loadb, r_loadc, r_loads, r_write;
    logic [2:0]  r_readnum, r_writenum;
    logic [1:0]  r_aluop, r_shift;

    // Next values of the registered outputs
    logic        w_nxt_w;
    logic [1:0]  w_nxt_vsel;
    logic        w_nxt_asel;
    logic        w_nxt_loada, w_nxt_loadb, w_nxt_loadc, w_nxt_loads, w_nxt_write;
    logic [2:0]  w_nxt_readnum, w_nxt_writenum;
    logic [1:0]  w_nxt_aluop, w_nxt_shift;

    // IR field extraction
    logic [2:0] w_opcode, w_rn, w_rd, w_rm;
    logic [1:0] w_op, w_sh;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    logic w_is_mov_imm, w_is_mov_reg, w_is_add, w_is_cmp, w_is_and, w_is_mvn;

    assign w_is_mov_imm = (w_opcode == c_OPC_MOV) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == c_OPC_MOV) && (w_op == 2'b00);
    assign w_is_add     = (w_opcode == c_OPC_ALU) && (w_op == 2'b00);
    assign w_is_cmp     = (w_opcode == c_OPC_ALU) && (w_op == 2'b01);
    assign w_is_and     = (w_opcode == c_OPC_ALU) && (w_op == 2'b10);
    assign w_is_mvn     = (w_opcode == c_OPC_ALU) && (w_op == 2'b11);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_WAIT: begin
                if (s) w_state_nxt = c_S_DECODE;
            end
            c_S_DECODE: begin
                if (w_is_mov_imm)
                    w_state_nxt = c_S_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn)
                    w_state_nxt = c_S_GET_B;   // single-operand ops skip GET_A
                else if (w_is_add || w_is_cmp || w_is_and)
                    w_state_nxt = c_S_GET_A;
`ifdef HALT_INSN_EN
                else if (w_opcode == c_OPC_HALT)
                    w_state_nxt = c_S_HALT;
`endif
                else
                    w_state_nxt = c_S_WAIT;    // undefined encoding: no side effects
            end
            c_S_WRITE_IMM: w_state_nxt = c_S_WAIT;
            c_S_GET_A:     w_state_nxt = c_S_GET_B;
            c_S_GET_B:     w_state_nxt = c_S_ALU;
            c_S_ALU:       w_state_nxt = w_is_cmp ? c_S_WAIT : c_S_WRITE_REG;
            c_S_WRITE_REG: w_state_nxt = c_S_WAIT;
`ifdef HALT_INSN_EN
            c_S_HALT:      w_state_nxt = c_S_HALT;
`endif
            default:       w_state_nxt = c_S_WAIT;
        endcase
    end

    // Output decode for the state being entered, so the outputs can be
    // registered and still line up with the state. IR only changes on the
    // WAIT->DECODE edge and DECODE has no IR-dependent outputs, so the
    // current IR is the right source here.
    always_comb begin
        w_nxt_w        = 1'b0;
        w_nxt_vsel     = 2'b00;
        w_nxt_asel     = 1'b0;
        w_nxt_loada    = 1'b0;
        w_nxt_loadb    = 1'b0;
        w_nxt_loadc    = 1'b0;
        w_nxt_loads    = 1'b0;
        w_nxt_write    = 1'b0;
        w_nxt_readnum  = 3'd0;
        w_nxt_writenum = 3'd0;
        w_nxt_aluop    = 2'b00;
        w_nxt_shift    = 2'b00;
        case (w_state_nxt)
            c_S_WAIT: w_nxt_w = 1'b1;
            c_S_WRITE_IMM: begin
                w_nxt_vsel     = 2'b01;
                w_nxt_writenum = w_rn;
                w_nxt_write    = 1'b1;
            end
            c_S_GET_A: begin
                w_nxt_readnum = w_rn;
                w_nxt_loada   = 1'b1;
            end
            c_S_GET_B: begin
                w_nxt_readnum = w_rm;
                w_nxt_loadb   = 1'b1;
            end
            c_S_ALU: begin
                w_nxt_shift = w_sh;
                w_nxt_loadc = 1'b1;
                // MOV reg passes B through as an ADD with A forced to zero
                w_nxt_aluop = (w_opcode == c_OPC_ALU) ? w_op : 2'b00;
                w_nxt_asel  = w_is_mov_reg || w_is_mvn;
                w_nxt_loads = w_is_cmp;
            end
            c_S_WRITE_REG: begin
                w_nxt_vsel     = 2'b11;
                w_nxt_writenum = w_rd;
                w_nxt_write    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_S_WAIT;
            r_ir       <= 16'h0000;
            r_w        <= 1'b1;
            r_vsel     <= 2'b00;
            r_asel     <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_write    <= 1'b0;
            r_readnum  <= 3'd0;
            r_writenum <= 3'd0;
            r_aluop    <= 2'b00;
            r_shift    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_S_WAIT) && load)
                r_ir <= in;
            r_w        <= w_nxt_w;
            r_vsel     <= w_nxt_vsel;
            r_asel     <= w_nxt_asel;
            r_loada    <= w_nxt_loada;
            r_loadb    <= w_nxt_loadb;
            r_loadc    <= w_nxt_loadc;
            r_loads    <= w_nxt_loads;
            r_write    <= w_nxt_write;
            r_readnum  <= w_nxt_readnum;
            r_writenum <= w_nxt_writenum;
            r_aluop    <= w_nxt_aluop;
            r_shift    <= w_nxt_shift;
        end
    end

`ifdef HALT_INSN_EN
    logic r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_halted <= 1'b0;
        else       r_halted <= (w_state_nxt == c_S_HALT);
    end

    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign w        = r_w;
    assign vsel     = r_vsel;
    assign asel     = r_asel;
    // No supported instruction uses the immediate B operand
    assign bsel     = 1'b0;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign write    = r_write;
    assign readnum  = r_readnum;
    assign writenum = r_writenum;
    assign ALUop    = r_aluop;
    assign shift    = r_shift;

    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_controller
//  Description : Self-checking bench for cpu_controller. Expected per-cycle
//                control vectors are queued when an instruction is issued
//                and popped/compared on every following clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w, halted, asel, bsel;
    logic        loada, loadb, loadc, loads, write;
    logic [1:0]  vsel, ALUop, shift;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm5, sximm8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] exp_q[$];
    logic [20:0] w_obs;

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .halted   (halted),
        .vsel     (vsel),
        .asel     (asel),
        .bsel     (bsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .readnum  (readnum),
        .writenum (writenum),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    always #5 clk = ~clk;

    assign w_obs = {w, halted, vsel, asel, bsel, loada, loadb, loadc, loads,
                    write, readnum, writenum, ALUop, shift};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Build an expected control vector (bsel is always 0)
    function automatic logic [20:0] mk(input logic ww, input logic hh, input logic [1:0] vs,
                                       input logic as, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic wr,
                                       input logic [2:0] rn, input logic [2:0] wn,
                                       input logic [1:0] aop, input logic [1:0] sh);
        return {ww, hh, vs, as, 1'b0, la, lb, lc, ls, wr, rn, wn, aop, sh};
    endfunction

    // Queue the vectors expected after each clock edge from the start edge
    task automatic push_expected(input logic [15:0] instr);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        opc = instr[15:13]; op = instr[12:11]; rn = instr[10:8];
        rd  = instr[7:5];   sh = instr[4:3];   rm = instr[2:0];
        exp_q.push_back(mk(0,0,2'b00,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00));          // DECODE
        if (opc == 3'b110 && op == 2'b10) begin
            exp_q.push_back(mk(0,0,2'b01,0,0,0,0,0,1,3'd0,rn,2'b00,2'b00));        // WRITE_IMM
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            exp_q.push_back(mk(0,0,2'b00,0,0,1,0,0,0,rm,3'd0,2'b00,2'b00));        // GET_B
            exp_q.push_back(mk(0,0,2'b00,1,0,0,1,0,0,3'd0,3'd0,
                               (opc == 3'b101) ? op : 2'b00, sh));                 // ALU
            exp_q.push_back(mk(0,0,2'b11,0,0,0,0,0,1,3'd0,rd,2'b00,2'b00));        // WRITE_REG
        end else if (opc == 3'b101) begin
            exp_q.push_back(mk(0,0,2'b00,0,1,0,0,0,0,rn,3'd0,2'b00,2'b00));        // GET_A
            exp_q.push_back(mk(0,0,2'b00,0,0,1,0,0,0,rm,3'd0,2'b00,2'b00));        // GET_B
            exp_q.push_back(mk(0,0,2'b00,0,0,0,1,(op == 2'b01),0,3'd0,3'd0,op,sh)); // ALU
            if (op != 2'b01)
                exp_q.push_back(mk(0,0,2'b11,0,0,0,0,0,1,3'd0,rd,2'b00,2'b00));    // WRITE_REG
        end
        exp_q.push_back(mk(1,0,2'b00,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00));          // WAIT
    endtask

    // Issue one instruction (load+s together) and compare every cycle until
    // the expected sequence is exhausted. With disturb set, a load of D005
    // and a spurious s are presented while the controller is in GET_B.
    task automatic run_insn(input logic [15:0] instr, input bit disturb);
        int n;
        logic [20:0] e;
        @(negedge clk);
        in = instr; load = 1'b1; s = 1'b1;
        push_expected(instr);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            load = 1'b0; s = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("insn %h cyc%0d", instr, n), {11'd0, w_obs}, {11'd0, e});
            if (disturb && n == 3) begin
                in = 16'hD005; load = 1'b1; s = 1'b1;
            end
        end
        if (exp_q.size() != 0) begin
            check("sequence timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    logic [20:0] c_wait_vec;

    initial begin
        c_wait_vec = mk(1,0,2'b00,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00);
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        #12;
        check("reset vector", {11'd0, w_obs}, {11'd0, c_wait_vec});
        check("reset sximm8", {16'd0, sximm8}, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        run_insn(16'hD007, 1'b0);                       // MOV R0,#7
        check("sximm8 D007", {16'd0, sximm8}, 32'h0000_0007);
        run_insn(16'hD1FE, 1'b0);                       // MOV R1,#-2
        check("sximm8 D1FE", {16'd0, sximm8}, 32'h0000_FFFE);
        check("sximm5 D1FE", {16'd0, sximm5}, 32'h0000_FFFE);
        run_insn(16'hA148, 1'b0);                       // ADD R2,R1,R0,LSL#1
        check("sximm5 A148", {16'd0, sximm5}, 32'h0000_0008);
        run_insn(16'hA801, 1'b0);                       // CMP R0,R1
        run_insn(16'hB860, 1'b0);                       // MVN R3,R0
        run_insn(16'hC0A9, 1'b0);                       // MOV R5,R1,LSL#1
        run_insn(16'hA148, 1'b1);                       // ADD with load/s during GET_B
        check("IR held sximm8", {16'd0, sximm8}, 32'h0000_0048);
        run_insn(16'h0000, 1'b0);                       // undefined: DECODE -> WAIT

        // Reset mid-GET_B aborts immediately
        @(negedge clk);
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("GET_B loadb", {31'd0, loadb}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset vec", {11'd0, w_obs}, {11'd0, c_wait_vec});
        check("async reset IR", {16'd0, sximm8}, 32'h0000_0000);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("post-reset idle", {11'd0, w_obs}, {11'd0, c_wait_vec});

`ifdef HALT_INSN_EN
        @(negedge clk);
        in = 16'hE000; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        check("halt decode", {11'd0, w_obs}, {11'd0, mk(0,0,2'b00,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00)});
        in = 16'hD007;                                  // load/s stay high: must be ignored
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("halted cyc%0d", i), {11'd0, w_obs},
                  {11'd0, mk(0,1,2'b00,0,0,0,0,0,0,3'd0,3'd0,2'b00,2'b00)});
        end
        check("halt IR held", {16'd0, sximm8}, 32'h0000_0000);
        load = 1'b0; s = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("halt reset", {11'd0, w_obs}, {11'd0, c_wait_vec});
        #1 reset = 1'b0;
`else
        run_insn(16'hE000, 1'b0);                       // opcode 111 undefined here
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction register, decoder and control FSM that sits directly upstream of the datapath and drives every datapath control input.
- Latches a 16-bit instruction.
- On start, sequences the datapath through read, execute and write-back one cycle per state.
- Reports idle on w.

Parameters:
None (ISA widths fixed: 16-bit instruction, 8 registers, 2-bit ALUop/shift/vsel).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
s  input  1  start execution of IR contents
load  input  1  capture in into IR (honoured only in WAIT)
in  input  16  instruction word
w  output  1  1 when in WAIT (ready for next instruction)
halted  output  1  1 in HALT state (only reachable with HALT_INSN_EN)
vsel  output  2  writeback select: 00 mdata, 01 sximm8, 10 PC, 11 C
asel  output  1  1 forces ALU A operand to 0
bsel  output  1  1 selects sximm5 as B operand
loada, loadb, loadc, loads  output  1 each  datapath register enables
write  output  1  register-file write enable
readnum, writenum  output  3 each  register-file addresses
ALUop  output  2  ALU operation
shift  output  2  shifter control
sximm5  output  16  sign-extended IR[4:0]
sximm8  output  16  sign-extended IR[7:0]

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
- IR:
  - Loads in at the clock edge when load=1 and state=WAIT; load is ignored in all other states.
  - load and s together in WAIT: the new IR is used by DECODE.
- Reset (async): state=WAIT, IR=0. All enables, addresses, ALUop, shift, asel, bsel and vsel are 0; w=1, halted=0.
- Moore outputs decoded from state+IR. Any enable/address not listed for a state is 0.
- sximm5 and sximm8 are combinational from IR at all times.
- WAIT: w=1. s=1 -> DECODE, else stay.
- DECODE (no enables):
  - MOV imm -> WRITE_IMM
  - MOV reg or MVN -> GET_B
  - ADD/CMP/AND -> GET_A
  - any other opcode/op -> WAIT, with no register/status side effect
- WRITE_IMM: vsel=01, writenum=Rn, write=1 -> WAIT.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> ALU.
- ALU:
  - Common outputs: shift=sh, bsel=0, loadc=1.
  - ALUop: op for opcode 101; 00 for MOV reg.
  - asel=1 for MOV reg and MVN, else 0.
  - loads=1 only for CMP.
  - CMP -> WAIT; others -> WRITE_REG.
- WRITE_REG: vsel=11, writenum=Rd, write=1 -> WAIT.
- Latency, s-sampling edge to w=1:
  - MOV imm: 3 cycles
  - MOV reg, MVN, CMP: 5 cycles
  - ADD, AND: 6 cycles
- s held high in WAIT immediately starts the next instruction; s is ignored outside WAIT.
- reset mid-instruction: aborts at once. No further write/load pulses; w=1 asynchronously.

Optional Feature:
Macro HALT_INSN_EN.
- Defined: opcode 111 in DECODE -> HALT state. In HALT:
  - halted=1, w=0, all enables 0.
  - s and load are ignored.
  - Only reset exits HALT.
- Undefined: opcode 111 is undefined (DECODE -> WAIT), HALT state does not exist, and halted is tied 0.

Test Plan:
1. Reset, then in=16'hD007 (MOV R0,#7) with load=1,s=1 -> next state DECODE; WRITE_IMM has write=1, vsel=01, writenum=0, sximm8=16'h0007; w=1 after 3rd edge.
2. in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE, writenum=1.
3. in=16'hA148 (ADD R2,R1,R0,LSL#1) -> expected sequence, w=1 after 6 edges:
   - GET_A: readnum=1, loada=1
   - GET_B: readnum=0, loadb=1
   - ALU: ALUop=00, shift=01, asel=0, bsel=0, loadc=1
   - WRITE_REG: vsel=11, writenum=2, write=1
4. in=16'hA801 (CMP R0,R1) -> ALU state asserts loads=1 with ALUop=01; write never 1; w=1 after 5 edges. in=16'hB860 (MVN R3,R0) -> GET_A skipped, ALU asel=1 ALUop=11, WRITE_REG writenum=3.
5. Pulse load with in=16'hD005 while in GET_B -> IR unchanged (sximm8 stays that of running instruction). in=16'h0000 with s -> DECODE then WAIT, no write/load pulses.
6. Assert reset asynchronously mid-GET_B of 16'hA148 -> w=1, loadb=0, IR=0 before next clock edge. With HALT_INSN_EN, in=16'hE000 -> halted=1, w=0, stays until reset.
